// File: rtl/display_endpoint.sv
// display_endpoint: Wishbone USB endpoint that double-buffers a 6-byte frame
// into seven-segment and LED drive, committing atomically on the sixth byte.
module display_endpoint #(
    parameter logic [3:0] ADDR = 4'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_cyc,
    input  logic       wb_stb,
    input  logic       wb_we,
    input  logic [3:0] wb_adr,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [7:0] LEDG,
    output logic [9:0] LEDR,
    output logic       disp_valid,
    output logic       disp_update
);
    localparam logic [47:0] D_RST = 48'h0000_0FFF_FFFF;

    logic [47:0] d_q, d_d, s_q, s_d;
    logic [2:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]  dat_o_q, dat_o_d;
    logic        ack_q, ack_d, valid_q, valid_d, upd_q, upd_d;
    logic        sel;

    always_comb begin
        sel     = wb_cyc & wb_stb & (wb_adr == ADDR) & !ack_q;
        d_d     = d_q;
        s_d     = s_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        ack_d   = sel;
        dat_o_d = 8'h00;
        valid_d = valid_q;
        upd_d   = 1'b0;
        if (!wb_cyc) begin
            s_d    = '0;
            wptr_d = 3'd0;
            rptr_d = 3'd0;
        end else if (sel && wb_we) begin
            s_d[{wptr_q, 3'b000} +: 8] = wb_dat_i;
            // the last byte is merged straight from the bus so D never sees a partial frame
            if (wptr_q == 3'd5) begin
                d_d     = {2'b00, wb_dat_i[5:0], s_q[39:0]};
                wptr_d  = 3'd0;
                upd_d   = 1'b1;
                valid_d = 1'b1;
            end else begin
                wptr_d = wptr_q + 3'd1;
            end
        end else if (sel) begin
            dat_o_d = d_q[{rptr_q, 3'b000} +: 8];
            rptr_d  = (rptr_q == 3'd5) ? 3'd0 : rptr_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q     <= D_RST;
            s_q     <= '0;
            wptr_q  <= 3'd0;
            rptr_q  <= 3'd0;
            ack_q   <= 1'b0;
            dat_o_q <= 8'h00;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            d_q     <= d_d;
            s_q     <= s_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ack_q   <= ack_d;
            dat_o_q <= dat_o_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
        end
    end

    assign wb_ack      = ack_q;
    assign wb_dat_o    = dat_o_q;
    assign disp_valid  = valid_q;
    assign disp_update = upd_q;
    assign HEX0        = d_q[6:0];
    assign HEX1        = d_q[13:7];
    assign HEX2        = d_q[20:14];
    assign HEX3        = d_q[27:21];
    assign LEDG        = d_q[35:28];
    assign LEDR        = d_q[45:36];
endmodule

// File: tb/tb_display_endpoint.sv
// tb_display_endpoint: directed Wishbone bursts with a queue-based scoreboard
// checking every ack, plus direct checks of the display outputs.
module tb_display_endpoint;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0] wb_adr = 4'd2;
    logic [7:0] wb_dat_i = 8'h00;
    logic [7:0] wb_dat_o;
    logic       wb_ack;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    logic [7:0] LEDG;
    logic [9:0] LEDR;
    logic       disp_valid, disp_update;

    typedef struct {logic rd; logic [7:0] dat; logic upd;} exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, ack_cnt = 0;

    display_endpoint #(.ADDR(4'd2)) dut (
        .clk(clk), .reset(reset), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .LEDG(LEDG), .LEDR(LEDR),
        .disp_valid(disp_valid), .disp_update(disp_update)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (wb_ack) begin
                ack_cnt++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: got ack with dat_o=%h, expected none", wb_dat_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ((e.rd && wb_dat_o !== e.dat) || disp_update !== e.upd) begin
                        errors++;
                        $display("FAIL ack_resp: rd=%0b dat_o=%h upd=%b, expected dat=%h upd=%b",
                                 e.rd, wb_dat_o, disp_update, e.dat, e.upd);
                    end
                end
            end else if (wb_dat_o !== 8'h00 || disp_update !== 1'b0) begin
                errors++;
                $display("FAIL idle: dat_o=%h upd=%b while ack low, expected 00/0", wb_dat_o, disp_update);
            end
        end
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] disp();
        return {2'b00, LEDR, LEDG, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic strobe(input logic we, input logic [7:0] b);
        bit got = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = 4'd2; wb_dat_i = b;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (wb_ack) got = 1;
        end
        wb_stb = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout: no ack for we=%b byte=%h", we, b);
        end
    endtask

    task automatic wr(input logic [7:0] b, input logic upd);
        q.push_back('{rd: 1'b0, dat: 8'h00, upd: upd});
        strobe(1'b1, b);
    endtask

    task automatic rd(input logic [7:0] e);
        q.push_back('{rd: 1'b1, dat: e, upd: 1'b0});
        strobe(1'b0, 8'h00);
    endtask

    task automatic wr6(input logic [47:0] v);
        for (int i = 0; i < 6; i++) wr(v[i*8 +: 8], i == 5);
    endtask

    task automatic drop_cyc();
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wrong_addr(input logic we);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = 4'd1; wb_dat_i = 8'h99;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("wrong_addr_no_ack", {47'd0, wb_ack}, 48'd0);
        end
        wb_stb = 1'b0; wb_adr = 4'd2;
    endtask

    initial begin
        int a0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_disp", disp(), 48'h0000_0FFF_FFFF);
        chk("reset_flags", {44'd0, disp_valid, disp_update, wb_ack, |wb_dat_o}, 48'd0);

        a0 = ack_cnt;
        wr6(48'hFF05_0403_0201);
        drop_cyc();
        chk("burst1_disp", disp(), 48'h3F05_0403_0201);
        chk("burst1_hex0", {41'd0, HEX0}, 48'h01);
        chk("burst1_ledr", {38'd0, LEDR}, 48'h3F0);
        chk("burst1_valid", {47'd0, disp_valid}, 48'd1);
        chk("burst1_acks", 48'(ack_cnt - a0), 48'd6);

        rd(8'h01); rd(8'h02); rd(8'h03); rd(8'h04); rd(8'h05); rd(8'h3F); rd(8'h01);
        drop_cyc();

        wr(8'hAA, 1'b0); wr(8'hBB, 1'b0); wr(8'hCC, 1'b0);
        drop_cyc();
        chk("partial_no_commit", disp(), 48'h3F05_0403_0201);
        wr6(48'h1615_1413_1211);
        drop_cyc();
        chk("burst2_disp", disp(), 48'h1615_1413_1211);

        wr(8'h21, 1'b0); wr(8'h22, 1'b0);
        wrong_addr(1'b1);
        rd(8'h11);
        wrong_addr(1'b0);
        chk("mid_burst_disp", disp(), 48'h1615_1413_1211);
        wr(8'h23, 1'b0); wr(8'h24, 1'b0); wr(8'h25, 1'b0); wr(8'h26, 1'b1);
        drop_cyc();
        chk("interleave_disp", disp(), 48'h2625_2423_2221);

        wr(8'h31, 1'b0); wr(8'h32, 1'b0); wr(8'h33, 1'b0); wr(8'h34, 1'b0);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        chk("async_reset_disp", disp(), 48'h0000_0FFF_FFFF);
        chk("async_reset_flags", {44'd0, disp_valid, disp_update, wb_ack, |wb_dat_o}, 48'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        wr6(48'h4645_4443_4241);
        drop_cyc();
        chk("post_reset_disp", disp(), 48'h0645_4443_4241);
        chk("post_reset_valid", {47'd0, disp_valid}, 48'd1);

        repeat (3) @(posedge clk);
        chk("queue_drained", 48'(q.size()), 48'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_endpoint.md
DISPLAY_ENDPOINT -- requirements
Module: display_endpoint

Interface
REQ-001 Parameter ADDR, default 4'd2, is the Wishbone address (USB endpoint number) this block decodes.
REQ-002 Port clk  input  1  system clock, 24 MHz; all state changes on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-004 Port wb_cyc  input  1  Wishbone cycle; high for the whole multi-byte transfer.
REQ-005 Port wb_stb  input  1  Wishbone strobe, one byte per strobe.
REQ-006 Port wb_we  input  1  1 = write, 0 = read.
REQ-007 Port wb_adr  input  4  endpoint address; compared with ADDR.
REQ-008 Port wb_dat_i  input  8  write data byte.
REQ-009 Port wb_dat_o  output  8  read data byte.
REQ-010 Port wb_ack  output  1  single-cycle acknowledge.
REQ-011 Port HEX0, HEX1, HEX2, HEX3  output  7 each  seven-segment drive, active-low segments.
REQ-012 Port LEDG  output  8  green LEDs.
REQ-013 Port LEDR  output  10  red LEDs.
REQ-014 Port disp_valid  output  1  high once any complete 6-byte write has committed since reset.
REQ-015 Port disp_update  output  1  one-cycle pulse on each commit.

Function
REQ-016 48-bit committed register D maps as {2'b0, LEDR[9:0], LEDG[7:0], HEX3, HEX2, HEX1, HEX0}: HEX0 = D[6:0], HEX1 = D[13:7], HEX2 = D[20:14], HEX3 = D[27:21], LEDG = D[35:28], LEDR = D[45:36], D[47:46] always 0.
REQ-017 Outputs are driven directly from D registers; no combinational path from Wishbone inputs to display outputs.
REQ-018 A strobe is selected when wb_cyc & wb_stb & (wb_adr == ADDR) & !wb_ack.
REQ-019 wb_ack is asserted exactly one cycle after a selected strobe and deasserted in the following cycle; back-to-back strobes are acked every second cycle.
REQ-020 Non-matching wb_adr: no ack, no state change, wb_dat_o = 8'h00.
REQ-021 Write: the byte is stored into a 48-bit shadow S at byte lane wptr (byte 0 = bits 7:0, little-endian); wptr increments 0..5.
REQ-022 When the write at wptr == 5 is acked, S with byte 5 merged (bits 47:46 forced 0) is copied into D in the same edge that asserts wb_ack; wptr wraps to 0; disp_update pulses in that ack cycle; disp_valid sets.
REQ-023 Partial writes never modify D; D changes only atomically on commit.
REQ-024 Read: wb_dat_o = byte rptr of D, registered and valid while wb_ack is high; rptr increments 0..5 and wraps to 0 after byte 5; byte 5 reads with bits 7:6 = 0.
REQ-025 wptr and rptr are independent; a read never moves wptr and vice versa.
REQ-026 Abort: wb_cyc low for at least one cycle clears wptr and rptr to 0 and discards S contents (next write restarts at byte 0); D is unaffected.
REQ-027 wb_dat_o is 8'h00 in every cycle in which wb_ack is low.

Reset
REQ-028 On reset low: D = 48'h0000_0FFF_FFFF (all segments blank, all LEDs off), S = 0, wptr = rptr = 0, wb_ack = 0, wb_dat_o = 0, disp_valid = 0, disp_update = 0.
REQ-029 Reset asserted mid-transfer aborts the transfer with no commit; after release the block accepts a fresh transfer starting at byte 0.

Verification
REQ-030 After reset release, sample outputs -> HEX0..HEX3 = 7'h7F, LEDG = 0, LEDR = 0, disp_valid = 0.
REQ-031 Write bytes 01,02,03,04,05,FF to ADDR 2 in one cycle -> D = 48'h3F05_0403_0201, HEX0 = 7'h01, LEDR[9:0] = 10'h3F0, disp_update pulses once on the sixth ack, 6 acks total.
REQ-032 Write 3 bytes AA,BB,CC, drop wb_cyc, then write 6 bytes 11..16 -> D unchanged after the first burst, D = 48'h1615_1413_1211 after the second (bits 47:46 = 0).
REQ-033 Read 7 bytes from ADDR 2 after REQ-031 -> 01,02,03,04,05,3F,01 (wraps, bits 7:6 of byte 5 = 0).
REQ-034 Strobes with wb_adr = 1 -> no wb_ack, no pointer or register change.
REQ-035 Assert reset after 4 of 6 write bytes -> D returns to 48'h0000_0FFF_FFFF immediately, wb_ack low, no disp_update.
